anf_fl_tex_etc2_block_fetch: RTL

Texel-request front end for the ETC2 block decoder. It maps a texel coordinate to its 128-bit compressed block address and serves blocks from a 2-entry block buffer. On a miss it fetches the block as a 4-beat 32-bit memory burst. It then presents the block plus the in-block texel offset to the decoder through a valid/ready output.

---
 rtl/anf_fl_tex_etc2_block_fetch_if.sv | 42 ++++
 rtl/anf_fl_tex_etc2_block_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/anf_fl_tex_etc2_block_fetch_if.sv
// Bundle of handshake buses for the ETC2 block fetch front end.
// It carries the texel request port, the memory burst request/response port
// and the decoder output port. The "slave" modport is the block fetch unit.
// The "master" modport is whatever drives requests and models memory and the decoder.
interface anf_fl_tex_etc2_block_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [11:0]       req_u;
  logic [11:0]       req_v;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;

  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;
  logic [1:0]        out_uTexel;
  logic [1:0]        out_vTexel;

  modport master (
    output req_valid, req_u, req_v,
    input  req_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  out_valid, out_data, out_uTexel, out_vTexel,
    output out_ready
  );

  modport slave (
    input  req_valid, req_u, req_v,
    output req_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output out_valid, out_data, out_uTexel, out_vTexel,
    input  out_ready
  );
endinterface

// File: rtl/anf_fl_tex_etc2_block_fetch.sv
// ETC2 block fetch front end.
// It maps a texel coordinate to the address of its 128-bit compressed block
// and serves the block from a 2-entry buffer. A miss fetches the block as
// one 4-beat 32-bit burst. The block and the in-block texel offset then go
// to the decoder over a valid/ready output.
module anf_fl_tex_etc2_block_fetch #(
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            texBase,
  input  logic [9:0]                   texPitchBlocks,
  input  logic                         inv,
  anf_fl_tex_etc2_block_fetch_if.slave bus
);

  localparam int TAG_W = ADDR_W - 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        entryValid;
  logic [TAG_W-1:0]  entryTag [2];
  logic [127:0]      entryData [2];
  logic              lru;
  logic              victim;
  logic [1:0]        beatCnt;
  logic              invSeen;
  logic [ADDR_W-1:0] missAddr;
  logic [1:0]        missU;
  logic [1:0]        missV;
  logic [127:0]      outData;
  logic [1:0]        outU;
  logic [1:0]        outV;

  logic [19:0]       rowProduct;
  logic [20:0]       blockIndex;
  logic [ADDR_W-1:0] baseAligned;
  logic [ADDR_W-1:0] reqAddr;
  logic [TAG_W-1:0]  reqTag;
  logic [1:0]        hitVec;
  logic              reqHit;
  logic              hitIdx;
  logic              allocIdx;
  logic              reqReady;
  logic              acceptReq;
  logic              missStart;
  logic              beatFire;
  logic              fillDone;

  // Block address and tag lookup for the request currently on the port.
  // OUT also accepts requests while the decoder drains, so this lookup is
  // live in both IDLE and OUT.
  always_comb begin
    rowProduct  = 20'(bus.req_v[11:2]) * 20'(texPitchBlocks);
    blockIndex  = 21'(rowProduct) + 21'(bus.req_u[11:2]);
    baseAligned = texBase & ~ADDR_W'(15);
    reqAddr     = baseAligned + ADDR_W'({blockIndex, 4'b0000});
    reqTag      = reqAddr[ADDR_W-1:4];
    hitVec[0]   = entryValid[0] && (entryTag[0] == reqTag);
    hitVec[1]   = entryValid[1] && (entryTag[1] == reqTag);
    reqHit      = |hitVec;
    hitIdx      = hitVec[1];
    if (!entryValid[0]) begin
      allocIdx = 1'b0;
    end else if (!entryValid[1]) begin
      allocIdx = 1'b1;
    end else begin
      allocIdx = lru;
    end
    reqReady  = (state == IDLE) || ((state == OUT) && bus.out_ready);
    acceptReq = bus.req_valid && reqReady;
    missStart = acceptReq && !reqHit;
    beatFire  = (state == FILL) && bus.mem_rsp_valid;
    fillDone  = beatFire && (beatCnt == 2'd3);
  end

  assign bus.req_ready     = reqReady;
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_req_addr  = missAddr;
  assign bus.out_valid     = (state == OUT);
  assign bus.out_data      = outData;
  assign bus.out_uTexel    = outU;
  assign bus.out_vTexel    = outV;

  // Main controller: lookup/accept, single outstanding burst, beat counting, and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lru      <= 1'b0;
      victim   <= 1'b0;
      beatCnt  <= 2'd0;
      invSeen  <= 1'b0;
      missAddr <= '0;
      missU    <= 2'd0;
      missV    <= 2'd0;
      outData  <= '0;
      outU     <= 2'd0;
      outV     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        entryTag[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, OUT: begin
          if (acceptReq) begin
            if (reqHit) begin
              outData <= entryData[hitIdx];
              outU    <= bus.req_u[1:0];
              outV    <= bus.req_v[1:0];
              lru     <= ~hitIdx;
              state   <= OUT;
            end else begin
              missAddr <= reqAddr;
              missU    <= bus.req_u[1:0];
              missV    <= bus.req_v[1:0];
              victim   <= allocIdx;
              invSeen  <= inv;
              state    <= REQ;
            end
          end else if ((state == OUT) && bus.out_ready) begin
            state <= IDLE;
          end
        end
        REQ: begin
          invSeen <= invSeen | inv;
          if (bus.mem_req_ready) begin
            beatCnt <= 2'd0;
            state   <= FILL;
          end
        end
        FILL: begin
          invSeen <= invSeen | inv;
          if (bus.mem_rsp_valid) begin
            beatCnt <= beatCnt + 2'd1;
            if (beatCnt == 2'd3) begin
              entryTag[victim] <= missAddr[ADDR_W-1:4];
              outData          <= {entryData[victim][127:32], bus.mem_rsp_data};
              outU             <= missU;
              outV             <= missV;
              lru              <= ~victim;
              state            <= OUT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: drop the victim when its refill starts, set it when the last beat lands, and clear everything on inv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entryValid <= 2'b00;
    end else begin
      if (missStart) begin
        entryValid[allocIdx] <= 1'b0;
      end
      if (fillDone && !invSeen) begin
        entryValid[victim] <= 1'b1;
      end
      if (inv) begin
        entryValid <= 2'b00;
      end
    end
  end

  // Block storage: the first beat goes to the top word, so the burst lands in big-word order without byte swapping.
  always_ff @(posedge clk) begin
    if (beatFire) begin
      case (beatCnt)
        2'd0:    entryData[victim][127:96] <= bus.mem_rsp_data;
        2'd1:    entryData[victim][95:64]  <= bus.mem_rsp_data;
        2'd2:    entryData[victim][63:32]  <= bus.mem_rsp_data;
        default: entryData[victim][31:0]   <= bus.mem_rsp_data;
      endcase
    end
  end

endmodule
